// File: rtl/encrypt_out_packer.sv
// encrypt_out_packer
//   Packs the ciphertext byte stream coming out of the encryption pipeline
//   into 32-bit words and queues them in a small FIFO. The FIFO is presented
//   on a valid/ready master interface. The encrypt side cannot be stalled, so
//   a word that arrives when the FIFO is full (and nothing leaves in the same
//   cycle) is dropped, and a sticky overflow flag is raised.
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   din      ciphertext byte
//   v_in     din valid strobe, one byte per asserted cycle
//   flush    pulse: push any partially filled word
//   clr_ovf  pulse: clear the sticky overflow flag
//   m_data   word at the FIFO head (0 when empty)
//   m_keep   byte-lane valid mask for m_data (0 when empty)
//   m_valid  FIFO non-empty
//   m_ready  downstream accepts m_data this cycle
//   level    FIFO occupancy
//   ovf      sticky overflow flag
module encrypt_out_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int LSB_FIRST  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    din,
  input  logic                          v_in,
  input  logic                          flush,
  input  logic                          clr_ovf,
  output logic [31:0]                   m_data,
  output logic [3:0]                    m_keep,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  // Accumulator state
  logic [31:0]        acc_p0;
  logic [3:0]         keep_acc_p0;
  logic [1:0]         byte_cnt;

  // Merged word and push request for the current cycle
  logic [1:0]         lane;
  logic [31:0]        word_p0;
  logic [3:0]         keep_p0;
  logic               vld_p0;

  // FIFO state
  logic [31:0]        mem_data [FIFO_DEPTH];
  logic [3:0]         mem_keep [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [LW-1:0]      count;
  logic               full;
  logic               pop;
  logic               push_ok;
  logic               ovf_set;

  // ---- Stage p0: merge incoming byte into the accumulator ----
  always_comb begin
    lane    = (LSB_FIRST != 0) ? byte_cnt : ~byte_cnt;
    word_p0 = acc_p0;
    keep_p0 = keep_acc_p0;
    if (v_in) begin
      word_p0[{lane, 3'b000} +: 8] = din;
      keep_p0[lane]                = 1'b1;
    end
    // A byte completing the word and a flush in the same cycle collapse
    // into a single push.
    vld_p0 = (v_in && (byte_cnt == 2'd3)) ||
             (flush && (v_in || (byte_cnt != 2'd0)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p0      <= '0;
      keep_acc_p0 <= '0;
      byte_cnt    <= '0;
    end else if (vld_p0) begin
      // The accumulator restarts even when the word is dropped on overflow.
      acc_p0      <= '0;
      keep_acc_p0 <= '0;
      byte_cnt    <= '0;
    end else if (v_in) begin
      acc_p0      <= word_p0;
      keep_acc_p0 <= keep_p0;
      byte_cnt    <= byte_cnt + 2'd1;
    end
  end

  // ---- Stage p1: FIFO ----
  assign full    = (count == LW'(FIFO_DEPTH));
  assign m_valid = (count != '0);
  assign pop     = m_valid && m_ready;
  // When full, a word may enter only into the slot freed by a same-cycle pop.
  assign push_ok = vld_p0 && (!full || pop);
  assign ovf_set = vld_p0 && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[wr_ptr] <= word_p0;
      mem_keep[wr_ptr] <= keep_p0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + LW'(push_ok) - LW'(pop);
      // Set has priority over clear.
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  assign m_data = m_valid ? mem_data[rd_ptr] : 32'h0;
  assign m_keep = m_valid ? mem_keep[rd_ptr] : 4'h0;
  assign level  = count;

endmodule

// File: tb/tb_encrypt_out_packer.sv
// tb_encrypt_out_packer
//   Directed bench for encrypt_out_packer (FIFO_DEPTH=4, LSB_FIRST=1).
//   Inputs change 1 ns after each rising edge; outputs are checked at the
//   same point, before the next edge.
module tb_encrypt_out_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        v_in;
  logic        flush;
  logic        clr_ovf;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  level;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

  encrypt_out_packer #(.FIFO_DEPTH(4), .LSB_FIRST(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .v_in    (v_in),
    .flush   (flush),
    .clr_ovf (clr_ovf),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .level   (level),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    din  = b;
    v_in = 1'b1;
    tick();
    v_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = '0; v_in = 1'b0; flush = 1'b0; clr_ovf = 1'b0; m_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf",   32'(ovf), 32'd0);
    chk("rst_data",  m_data, 32'h0);
    chk("rst_keep",  32'(m_keep), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Full word, popped immediately
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("w1_valid", 32'(m_valid), 32'd1);
    chk("w1_data",  m_data, 32'h44332211);
    chk("w1_keep",  32'(m_keep), 32'hF);
    chk("w1_level", 32'(level), 32'd1);
    tick();
    chk("w1_pop_level", 32'(level), 32'd0);
    chk("w1_pop_data",  m_data, 32'h0);

    // Partial word via flush, then an empty flush
    send(8'hAA); send(8'hBB);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl_data",  m_data, 32'h0000BBAA);
    chk("fl_keep",  32'(m_keep), 32'h3);
    chk("fl_level", 32'(level), 32'd1);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl_empty_level", 32'(level), 32'd0);
    chk("fl_empty_valid", 32'(m_valid), 32'd0);

    // Last byte and flush together give one word
    send(8'h01); send(8'h02); send(8'h03);
    din = 8'h04; v_in = 1'b1; flush = 1'b1; tick(); v_in = 1'b0; flush = 1'b0;
    chk("flv_data",  m_data, 32'h04030201);
    chk("flv_keep",  32'(m_keep), 32'hF);
    chk("flv_level", 32'(level), 32'd1);
    tick();
    chk("flv_drain", 32'(level), 32'd0);

    // Overflow: five words into a four-deep FIFO
    m_ready = 1'b0;
    for (int k = 0; k < 16; k++) send(8'(k + 1));
    chk("ov_full_level", 32'(level), 32'd4);
    chk("ov_full_ovf",   32'(ovf), 32'd0);
    for (int k = 16; k < 20; k++) send(8'(k + 1));
    chk("ov_level", 32'(level), 32'd4);
    chk("ov_ovf",   32'(ovf), 32'd1);
    chk("ov_hold",  m_data, 32'h04030201);
    m_ready = 1'b1;
    tick(); chk("ov_d1", m_data, 32'h08070605);
    tick(); chk("ov_d2", m_data, 32'h0C0B0A09);
    tick(); chk("ov_d3", m_data, 32'h100F0E0D);
    chk("ov_d3_level", 32'(level), 32'd1);
    tick(); chk("ov_empty", 32'(level), 32'd0);
    chk("ov_sticky", 32'(ovf), 32'd1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("ov_clr", 32'(ovf), 32'd0);

    // Full FIFO with pop on the cycle a new word completes
    m_ready = 1'b0;
    for (int k = 0; k < 16; k++) send(8'(8'h20 + k));
    send(8'h30); send(8'h31); send(8'h32);
    chk("fp_pre_level", 32'(level), 32'd4);
    din = 8'h33; v_in = 1'b1; m_ready = 1'b1; tick(); v_in = 1'b0;
    chk("fp_level", 32'(level), 32'd4);
    chk("fp_ovf",   32'(ovf), 32'd0);
    chk("fp_head",  m_data, 32'h27262524);
    tick(); chk("fp_d2", m_data, 32'h2B2A2928);
    tick(); chk("fp_d3", m_data, 32'h2F2E2D2C);
    tick(); chk("fp_new", m_data, 32'h33323130);
    tick(); chk("fp_empty", 32'(level), 32'd0);

    // Async reset with queued words and a partial word
    m_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(8'(8'h40 + k));
    send(8'h55); send(8'h66);
    chk("ar_pre_level", 32'(level), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(m_valid), 32'd0);
    chk("ar_level", 32'(level), 32'd0);
    chk("ar_data",  m_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    send(8'h77); send(8'h88);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("ar_fresh_data", m_data, 32'h00008877);
    chk("ar_fresh_keep", 32'(m_keep), 32'h3);
    chk("ar_fresh_level", 32'(level), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/encrypt_out_packer.md
Name: encrypt_out_packer

Overview:
- Sits directly downstream of the encryption pipeline and consumes its byte stream (8-bit data plus a one-cycle valid strobe).
- Packs ciphertext bytes into 32-bit words and buffers them in a small FIFO.
- Presents the words on a valid/ready master interface to the bus/output side.
- The encrypt side has no backpressure, so the block detects overflow, drops the affected words and flags them with a sticky error.

Parameters:
- FIFO_DEPTH, 4, number of 32-bit word entries; power of 2, minimum 2.
- LSB_FIRST, 1, 1: first byte of a word goes to bits [7:0]; 0: first byte goes to bits [31:24].

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  8  ciphertext byte from the encrypt stage.
- v_in  input  1  din valid; single-cycle strobe, one byte per asserted cycle.
- flush  input  1  pulse; emits any partially filled word.
- clr_ovf  input  1  pulse; clears the sticky overflow flag.
- m_data  output  32  packed word at the FIFO head.
- m_keep  output  4  byte-valid mask for m_data; bit i set means byte lane i is valid.
- m_valid  output  1  FIFO non-empty.
- m_ready  input  1  downstream accepts m_data this cycle.
- level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- ovf  output  1  sticky overflow indicator.

Behaviour:
- Reset (rst=1, async): accumulator cleared, byte_cnt=0, FIFO emptied. Outputs: m_valid=0, m_data=0, m_keep=0, level=0, ovf=0. Any partial word in progress is discarded; no flush occurs.
- Accumulator: a 32-bit shift/lane register plus a 2-bit byte_cnt. On v_in=1, din is written to lane byte_cnt (LSB_FIRST=1) or lane 3-byte_cnt (LSB_FIRST=0), and byte_cnt increments modulo 4.
- Word push: on the cycle v_in=1 with byte_cnt=3, the completed word (keep=4'b1111) is pushed into the FIFO. byte_cnt wraps to 0 and the lanes clear.
- Latency: the word completed at edge N is visible with m_valid=1 immediately after edge N, i.e. one clock from the last byte's strobe.
- Flush:
  - flush=1 with byte_cnt>0 pushes the partial word. Unused lanes are 0 and m_keep holds only the filled lanes (for LSB_FIRST=1, lanes 0..byte_cnt-1).
  - flush=1 with byte_cnt=0 and v_in=0 does nothing.
  - flush and v_in in the same cycle: the byte is merged first, then the result is pushed. If that byte completes the word, exactly one full word is pushed, not two.
- FIFO: a circular buffer with read/write pointers and a FIFO_DEPTH-deep memory.
  - m_data and m_keep come from the head entry and are 0 when empty.
  - Pop occurs when m_valid and m_ready are both 1.
  - When full, a push is accepted only if a pop happens in the same cycle; level is then unchanged.
  - Push and pop in the same cycle at any non-full level leave level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow: if a push is required while level=FIFO_DEPTH and no pop occurs, the word is dropped, FIFO contents are unchanged and ovf is set. The accumulator still clears (byte_cnt=0).
- ovf stays set until clr_ovf=1. If clr_ovf and a new overflow occur in the same cycle, the set wins (ovf stays 1).
- m_ready is ignored when m_valid=0. m_data and m_keep must stay stable while m_valid=1 and m_ready=0.
- No combinational path from din or v_in to any output; all outputs are registered or driven from FIFO state.

Test Plan:
- Reset then bytes 0x11,0x22,0x33,0x44 on consecutive cycles (LSB_FIRST=1, m_ready=1) -> after the 4th edge, m_valid=1, m_data=0x44332211, m_keep=4'hF; popped the next cycle; level returns to 0.
- Bytes 0xAA,0xBB, then flush pulse -> one word m_data=0x0000BBAA, m_keep=4'b0011; byte_cnt back to 0; flush with no pending bytes then produces nothing.
- Bytes 0x01,0x02,0x03, then 0x04 with flush in the same cycle -> exactly one word 0x04030201, keep=4'hF, level=1.
- m_ready=0, stream 20 bytes (5 words) with FIFO_DEPTH=4 -> level=4, ovf=1, fifth word dropped. Then m_ready=1 -> words 1..4 drain in order. clr_ovf -> ovf=0.
- FIFO full with m_ready=1 on the same cycle a new word completes -> head popped, new word accepted, level stays 4, ovf stays 0.
- Assert rst mid-word (after 2 bytes) and with 2 words queued -> m_valid=0, level=0 immediately (async). Bytes after reset release start a fresh word in lane 0.
